mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_wdog.sv | 33 +++
 rtl/mem_port_arb.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Holds the arbiter state enum, default bus widths and word size.
package mem_arb_pkg;

  localparam int AW_DEF     = 32;
  localparam int DW_DEF     = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    IF_ACC,
    X_ACC1,
    X_ACC2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog for the arbiter memory port (built only with MEM_ARB_TMO_EN).
// Ports: clk_i, rst_i (sync, active-low), req_i, ack_i, expire_o.
`ifdef MEM_ARB_TMO_EN
module mem_arb_wdog #(
  parameter int TMO_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt_q;

  // Fires on the TMO_CYC-th consecutive request cycle without ack.
  assign expire_o = req_i & ~ack_i
                  & (cnt_q == CW'(TMO_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (!req_i || ack_i || expire_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arb.sv
// Arbitrates fetch and execute requests onto one memory port.
// Ports: clk_i, rst_i (sync, active-low); fetch if_*; execute x_*;
// memory mem_*; hazards stall_fetch_o, stall_decode_o and, with
// MEM_ARB_TMO_EN defined, timeout_o plus a no-ack watchdog.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TMO_CYC = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_valid_o,
  input  logic          x_req_i,
  input  logic          x_we_i,
  input  logic          x_two_i,
  input  logic [AW-1:0] x_addr_i,
  input  logic [DW-1:0] x_wdata_i,
  output logic [DW-1:0] x_rdata_o,
  output logic          x_done_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          stall_fetch_o,
  output logic          stall_decode_o
`ifdef MEM_ARB_TMO_EN
  ,
  output logic          timeout_o
`endif
);

  arb_state_t    state_q, state_d;
  logic          two_q, two_d;
  logic          req_d, we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic [DW-1:0] if_rdata_d, x_rdata_d;
  logic          if_valid_d, x_done_d;
  logic          acc, arb, in_x;

  // An ack only counts while a request is outstanding.
  assign acc  = mem_req_o & mem_ack_i;
  assign in_x = (state_q == X_ACC1) | (state_q == X_ACC2);

  assign stall_decode_o = rst_i & ~x_done_o & (in_x | x_req_i);
  assign stall_fetch_o  = stall_decode_o
                        | (rst_i & (state_q == IF_ACC) & ~mem_ack_i);

`ifdef MEM_ARB_TMO_EN
  logic tmo_hit;

  mem_arb_wdog #(
    .TMO_CYC (TMO_CYC)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (mem_req_o),
    .ack_i    (mem_ack_i),
    .expire_o (tmo_hit)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      timeout_o <= 1'b0;
    end else if (tmo_hit) begin
      timeout_o <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    two_d      = two_q;
    req_d      = mem_req_o;
    we_d       = mem_we_o;
    addr_d     = mem_addr_o;
    wdata_d    = mem_wdata_o;
    if_rdata_d = if_rdata_o;
    x_rdata_d  = x_rdata_o;
    if_valid_d = 1'b0;
    x_done_d   = 1'b0;
    arb        = 1'b0;

    unique case (state_q)
      IDLE: begin
        arb = 1'b1;
      end
      IF_ACC: begin
        if (acc) begin
          if_rdata_d = mem_rdata_i;
          if_valid_d = 1'b1;
          arb        = 1'b1;
        end
      end
      X_ACC1: begin
        if (acc) begin
          if (two_q) begin
            state_d = X_ACC2;
            addr_d  = mem_addr_o + AW'(WORD_BYTES);
          end else begin
            if (!mem_we_o) begin
              x_rdata_d = mem_rdata_i;
            end
            x_done_d = 1'b1;
            arb      = 1'b1;
          end
        end
      end
      X_ACC2: begin
        if (acc) begin
          if (!mem_we_o) begin
            x_rdata_d = mem_rdata_i;
          end
          x_done_d = 1'b1;
          arb      = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    // Re-arbitrate in the completing cycle so back-to-back
    // accesses see no idle bubble; execute has priority.
    if (arb) begin
      if (x_req_i) begin
        state_d = X_ACC1;
        req_d   = 1'b1;
        we_d    = x_we_i;
        addr_d  = x_addr_i;
        wdata_d = x_wdata_i;
        two_d   = x_two_i;
      end else if (if_req_i) begin
        state_d = IF_ACC;
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = if_addr_i;
      end else begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    end

`ifdef MEM_ARB_TMO_EN
    // A stuck access is dropped and its owner released with zero data.
    if (tmo_hit) begin
      state_d = IDLE;
      req_d   = 1'b0;
      we_d    = 1'b0;
      if (state_q == IF_ACC) begin
        if_rdata_d = '0;
        if_valid_d = 1'b1;
      end else begin
        x_rdata_d = '0;
        x_done_d  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      two_q       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      x_rdata_o   <= '0;
      if_valid_o  <= 1'b0;
      x_done_o    <= 1'b0;
    end else begin
      state_q     <= state_d;
      two_q       <= two_d;
      mem_req_o   <= req_d;
      mem_we_o    <= we_d;
      mem_addr_o  <= addr_d;
      mem_wdata_o <= wdata_d;
      if_rdata_o  <= if_rdata_d;
      x_rdata_o   <= x_rdata_d;
      if_valid_o  <= if_valid_d;
      x_done_o    <= x_done_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: per-cycle vector table plus
// a watchdog sequence when MEM_ARB_TMO_EN is defined.
module tb_mem_port_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          x_req, x_we, x_two;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata, x_rdata;
  logic          x_done;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          stall_f, stall_d;
`ifdef MEM_ARB_TMO_EN
  logic          timeout;
`endif

  always #5 clk = ~clk;

  mem_port_arb #(
    .AW      (AW),
    .DW      (DW),
    .TMO_CYC (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .if_req_i       (if_req),
    .if_addr_i      (if_addr),
    .if_rdata_o     (if_rdata),
    .if_valid_o     (if_valid),
    .x_req_i        (x_req),
    .x_we_i         (x_we),
    .x_two_i        (x_two),
    .x_addr_i       (x_addr),
    .x_wdata_i      (x_wdata),
    .x_rdata_o      (x_rdata),
    .x_done_o       (x_done),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_ack_i      (mem_ack),
    .mem_rdata_i    (mem_rdata),
    .stall_fetch_o  (stall_f),
    .stall_decode_o (stall_d)
`ifdef MEM_ARB_TMO_EN
    ,
    .timeout_o      (timeout)
`endif
  );

  typedef struct {
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        xr, xw, x2;
    logic [31:0] xa, xd;
    logic        ak;
    logic [31:0] rd;
    logic        e_rq, e_we;
    logic [31:0] e_ad, e_wd;
    logic        e_fv;
    logic [31:0] e_fd;
    logic        e_xd;
    logic [31:0] e_xr;
    logic        e_sf, e_sd;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic row(
    input logic r, fr, input logic [31:0] fa,
    input logic xr_, xw_, x2_,
    input logic [31:0] xa_, xd_,
    input logic ak, input logic [31:0] rd_,
    input logic rq, we, input logic [31:0] ad, wd,
    input logic fv, input logic [31:0] fd,
    input logic xd, input logic [31:0] xrd,
    input logic sf, sd);
    vec_t v;
    v.rst = r;   v.ifr = fr;  v.ifa = fa;
    v.xr = xr_;  v.xw = xw_;  v.x2 = x2_;
    v.xa = xa_;  v.xd = xd_;  v.ak = ak;
    v.rd = rd_;  v.e_rq = rq; v.e_we = we;
    v.e_ad = ad; v.e_wd = wd; v.e_fv = fv;
    v.e_fd = fd; v.e_xd = xd; v.e_xr = xrd;
    v.e_sf = sf; v.e_sd = sd;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm,
                       input logic [133:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst = 1'b1; if_req = 0; if_addr = '0;
    x_req = 0; x_we = 0; x_two = 0;
    x_addr = '0; x_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // rst ifr ifa xr xw x2 xa xd ak rd |
    // req we addr wdata ifv ifd xdn xrd sf sd
    row(0,0,0,0,0,0,0,0,0,0,
        0,0,0,0,0,0,0,0,0,0);
    // single fetch, ack on second request cycle
    row(1,1,'h100,0,0,0,0,0,0,0,
        0,0,0,0,0,0,0,0,0,0);
    row(1,1,'h100,0,0,0,0,0,0,0,
        1,0,'h100,0,0,0,0,0,1,0);
    row(1,0,0,0,0,0,0,0,1,'hDEADBEEF,
        1,0,'h100,0,0,0,0,0,0,0);
    row(1,0,0,0,0,0,0,0,0,0,
        0,0,'h100,0,1,'hDEADBEEF,0,0,0,0);
    row(1,0,0,0,0,0,0,0,0,0,
        0,0,'h100,0,0,'hDEADBEEF,0,0,0,0);
    // simultaneous requests: execute first
    row(1,1,'h300,1,0,0,'h200,0,0,0,
        0,0,'h100,0,0,'hDEADBEEF,0,0,1,1);
    row(1,1,'h300,0,0,0,0,0,0,0,
        1,0,'h200,0,0,'hDEADBEEF,0,0,1,1);
    row(1,1,'h300,0,0,0,0,0,1,'hAAAA5555,
        1,0,'h200,0,0,'hDEADBEEF,0,0,1,1);
    row(1,1,'h300,0,0,0,0,0,0,0,
        1,0,'h300,0,0,'hDEADBEEF,1,'hAAAA5555,1,0);
    row(1,0,0,0,0,0,0,0,1,'h0BADF00D,
        1,0,'h300,0,0,'hDEADBEEF,0,'hAAAA5555,0,0);
    // ack while idle is ignored
    row(1,0,0,0,0,0,0,0,1,'h77777777,
        0,0,'h300,0,1,'h0BADF00D,0,'hAAAA5555,0,0);
    // two-beat read wrapping the address
    row(1,0,0,1,0,1,'hFFFFFFFC,0,0,0,
        0,0,'h300,0,0,'h0BADF00D,0,'hAAAA5555,1,1);
    row(1,0,0,0,0,0,0,0,1,'h11111111,
        1,0,'hFFFFFFFC,0,0,'h0BADF00D,0,'hAAAA5555,1,1);
    row(1,0,0,0,0,0,0,0,0,0,
        1,0,0,0,0,'h0BADF00D,0,'hAAAA5555,1,1);
    row(1,0,0,0,0,0,0,0,1,'h22222222,
        1,0,0,0,0,'h0BADF00D,0,'hAAAA5555,1,1);
    row(1,0,0,0,0,0,0,0,0,0,
        0,0,0,0,0,'h0BADF00D,1,'h22222222,0,0);
    row(1,0,0,0,0,0,0,0,0,0,
        0,0,0,0,0,'h0BADF00D,0,'h22222222,0,0);
    // write, request dropped after grant
    row(1,0,0,1,1,0,'h400,'h12345678,0,0,
        0,0,0,0,0,'h0BADF00D,0,'h22222222,1,1);
    row(1,0,0,0,0,0,0,0,0,0,
        1,1,'h400,'h12345678,0,'h0BADF00D,0,'h22222222,1,1);
    row(1,0,0,0,0,0,0,0,1,'h99999999,
        1,1,'h400,'h12345678,0,'h0BADF00D,0,'h22222222,1,1);
    row(1,0,0,0,0,0,0,0,0,0,
        0,0,'h400,'h12345678,0,'h0BADF00D,1,'h22222222,0,0);
    // back-to-back fetches with no bubble
    row(1,1,'h500,0,0,0,0,0,0,0,
        0,0,'h400,'h12345678,0,'h0BADF00D,0,'h22222222,0,0);
    row(1,1,'h504,0,0,0,0,0,1,'hA0A0A0A0,
        1,0,'h500,'h12345678,0,'h0BADF00D,0,'h22222222,0,0);
    row(1,0,0,0,0,0,0,0,1,'hB0B0B0B0,
        1,0,'h504,'h12345678,1,'hA0A0A0A0,0,'h22222222,0,0);
    row(1,0,0,0,0,0,0,0,0,0,
        0,0,'h504,'h12345678,1,'hB0B0B0B0,0,'h22222222,0,0);
    // reset during second beat
    row(1,0,0,1,0,1,'h600,0,0,0,
        0,0,'h504,'h12345678,0,'hB0B0B0B0,0,'h22222222,1,1);
    row(1,0,0,0,0,0,0,0,1,'h44444444,
        1,0,'h600,0,0,'hB0B0B0B0,0,'h22222222,1,1);
    row(1,0,0,0,0,0,0,0,0,0,
        1,0,'h604,0,0,'hB0B0B0B0,0,'h22222222,1,1);
    row(0,0,0,0,0,0,0,0,1,'h33333333,
        1,0,'h604,0,0,'hB0B0B0B0,0,'h22222222,0,0);
    row(1,0,0,0,0,0,0,0,0,0,
        0,0,0,0,0,0,0,0,0,0);
    row(1,0,0,0,0,0,0,0,0,0,
        0,0,0,0,0,0,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst;   if_req = tbl[i].ifr;
      if_addr = tbl[i].ifa;
      x_req = tbl[i].xr;  x_we = tbl[i].xw;
      x_two = tbl[i].x2;  x_addr = tbl[i].xa;
      x_wdata = tbl[i].xd;
      mem_ack = tbl[i].ak; mem_rdata = tbl[i].rd;
      #1;
      check($sformatf("vec%0d", i),
        {mem_req, mem_we, mem_addr, mem_wdata,
         if_valid, if_rdata, x_done, x_rdata,
         stall_f, stall_d},
        {tbl[i].e_rq, tbl[i].e_we, tbl[i].e_ad,
         tbl[i].e_wd, tbl[i].e_fv, tbl[i].e_fd,
         tbl[i].e_xd, tbl[i].e_xr,
         tbl[i].e_sf, tbl[i].e_sd});
    end

`ifdef MEM_ARB_TMO_EN
    begin
      int cyc;
      @(negedge clk);
      drive_idle();
      check("tmo_reset", 134'(timeout), 134'(0));
      // plain read so a later zero is meaningful
      x_req = 1; x_addr = 'h710;
      @(negedge clk);
      x_req = 0; mem_ack = 1; mem_rdata = 'hCAFEF00D;
      @(negedge clk);
      mem_ack = 0; mem_rdata = 'h5A5A5A5A;
      check("pre_rdata", 134'(x_rdata),
            134'(32'hCAFEF00D));
      x_req = 1; x_addr = 'h700;
      @(negedge clk);
      x_req = 0;
      cyc = 0;
      while (mem_req && cyc < 50) begin
        cyc++;
        @(negedge clk);
      end
      check("tmo_cycles", 134'(cyc), 134'(8));
      check("tmo_done", 134'({x_done, x_rdata}),
            134'({1'b1, 32'h0}));
      check("tmo_flag", 134'(timeout), 134'(1));
      repeat (3) @(negedge clk);
      check("tmo_sticky",
            134'({timeout, x_done, mem_req}),
            134'(3'b100));
      rst = 0;
      @(negedge clk);
      check("tmo_clear", 134'(timeout), 134'(0));
      rst = 1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
